// File: rtl/fir_coef_reload_ctrl.sv
// Loads generator half-coefficients into the inactive bank (tap k, then NTAPS-1-k) and swaps banks on swap_ok.
// Each write follows its gen_valid by one cycle; requests arriving while busy are held and replayed from IDLE.
module fir_coef_reload_ctrl #(
    parameter int NTAPS   = 100,
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_req,
    input  logic [15:0]       cfg_fs,
    input  logic [15:0]       cfg_f_ln,
    output logic              gen_en,
    output logic [15:0]       gen_fs,
    output logic [15:0]       gen_f_ln,
    input  logic              gen_valid,
    input  logic [15:0]       gen_value,
    output logic              coef_we,
    output logic [ADDR_W:0]   coef_waddr,
    output logic [15:0]       coef_wdata,
    input  logic              swap_ok,
    output logic              active_bank,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int HALF = NTAPS / 2;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NTAPS - 1);
    localparam logic [ADDR_W-1:0] HALF_M1  = ADDR_W'(HALF - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MIRROR,
        WAIT_SWAP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] k;
    logic [WD_W-1:0]   wd;
    logic [15:0]       hold;
    logic              pend;
    logic [15:0]       pend_fs;
    logic [15:0]       pend_f_ln;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            wd          <= '0;
            hold        <= '0;
            pend        <= 1'b0;
            pend_fs     <= '0;
            pend_f_ln   <= '0;
            gen_en      <= 1'b0;
            gen_fs      <= '0;
            gen_f_ln    <= '0;
            coef_we     <= 1'b0;
            coef_waddr  <= '0;
            coef_wdata  <= '0;
            active_bank <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            coef_we <= 1'b0;
            done    <= 1'b0;

            // Requests during a load (including the cycle that returns to IDLE) are parked, last one wins.
            if (state != IDLE && cfg_req) begin
                pend      <= 1'b1;
                pend_fs   <= cfg_fs;
                pend_f_ln <= cfg_f_ln;
            end

            case (state)
                IDLE: begin
                    if (pend || cfg_req) begin
                        if (pend) begin
                            gen_fs   <= pend_fs;
                            gen_f_ln <= pend_f_ln;
                            pend     <= cfg_req;
                            if (cfg_req) begin
                                pend_fs   <= cfg_fs;
                                pend_f_ln <= cfg_f_ln;
                            end
                        end else begin
                            gen_fs   <= cfg_fs;
                            gen_f_ln <= cfg_f_ln;
                        end
                        err    <= 1'b0;
                        k      <= '0;
                        wd     <= '0;
                        gen_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end

                LOAD: begin
                    if (gen_valid) begin
                        coef_we    <= 1'b1;
                        coef_waddr <= {~active_bank, k};
                        coef_wdata <= gen_value;
                        hold       <= gen_value;
                        wd         <= '0;
                        if (k == HALF_M1) begin
                            gen_en <= 1'b0;
                        end
                        state <= MIRROR;
                    end else if (wd == WD_LIMIT) begin
                        err    <= 1'b1;
                        gen_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end

                MIRROR: begin
                    coef_we    <= 1'b1;
                    coef_waddr <= {~active_bank, LAST_TAP - k};
                    coef_wdata <= hold;
                    if (k == HALF_M1) begin
                        state <= WAIT_SWAP;
                    end else begin
                        k     <= k + 1'b1;
                        wd    <= '0;
                        state <= LOAD;
                    end
                end

                WAIT_SWAP: begin
                    if (swap_ok) begin
                        active_bank <= ~active_bank;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_reload_ctrl.sv
// Scoreboard bench for fir_coef_reload_ctrl: stimulus queues expected writes/configs/swaps, a monitor pops and compares.
module tb_fir_coef_reload_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [15:0] cfg_fs, cfg_f_ln;
    logic        gen_en;
    logic [15:0] gen_fs, gen_f_ln;
    logic        gen_valid;
    logic [15:0] gen_value;
    logic        coef_we;
    logic [7:0]  coef_waddr;
    logic [15:0] coef_wdata;
    logic        swap_ok;
    logic        active_bank, busy, done, err;

    fir_coef_reload_ctrl #(.NTAPS(100), .ADDR_W(7), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .cfg_req(cfg_req), .cfg_fs(cfg_fs), .cfg_f_ln(cfg_f_ln),
        .gen_en(gen_en), .gen_fs(gen_fs), .gen_f_ln(gen_f_ln),
        .gen_valid(gen_valid), .gen_value(gen_value),
        .coef_we(coef_we), .coef_waddr(coef_waddr), .coef_wdata(coef_wdata),
        .swap_ok(swap_ok), .active_bank(active_bank),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          wr_cnt = 0;
    logic [23:0] exp_wr_q[$];
    logic [31:0] exp_cfg_q[$];
    logic        exp_done_q[$];
    int          wr_cyc_q[$];
    logic [31:0] cur_cfg = '0;
    logic        prev_gen_en = 1'b0;
    logic        exp_ab = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT-presented event against the queued expectation.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) exp_wr_q.delete();
        if (coef_we === 1'b1) begin
            wr_cnt++;
            wr_cyc_q.push_back(cyc);
            check("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) check("write_addr_data", {8'd0, coef_waddr, coef_wdata}, {8'd0, exp_wr_q.pop_front()});
        end
        if (gen_en === 1'b1 && !prev_gen_en) begin
            check("load_expected", 32'(exp_cfg_q.size() != 0), 32'd1);
            if (exp_cfg_q.size() != 0) cur_cfg = exp_cfg_q.pop_front();
        end
        if (gen_en === 1'b1) check("gen_cfg", {gen_fs, gen_f_ln}, cur_cfg);
        prev_gen_en = (gen_en === 1'b1);
        if (done === 1'b1) begin
            check("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
            if (exp_done_q.size() != 0) check("done_bank", 32'(active_bank), 32'(exp_done_q.pop_front()));
        end
    end

    task automatic issue_cfg(input logic [15:0] fs, input logic [15:0] fl);
        @(negedge clk);
        cfg_req = 1'b1; cfg_fs = fs; cfg_f_ln = fl;
        @(negedge clk);
        cfg_req = 1'b0;
    endtask

    task automatic wait_gen_en();
        int n = 0;
        while (gen_en !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("gen_en_rise_in_time", 32'(gen_en), 32'd1);
    endtask

    // Generator model: nt pulses, one every 'period' cycles; returns on the negedge after the last pulse.
    task automatic gen_taps(input int nt, input logic [15:0] base, input int period);
        for (int t = 0; t < nt; t++) begin
            @(negedge clk);
            gen_valid = 1'b1;
            gen_value = base + 16'(t);
            exp_wr_q.push_back({~exp_ab, 7'(t), base + 16'(t)});
            exp_wr_q.push_back({~exp_ab, 7'(99 - t), base + 16'(t)});
            @(negedge clk);
            gen_valid = 1'b0;
            if (t != nt - 1) repeat (period - 2) @(negedge clk);
        end
    endtask

    task automatic run_load(input logic [15:0] base, input int period, input int gate);
        int n0 = wr_cnt;
        wait_gen_en();
        gen_taps(50, base, period);
        repeat (2) @(negedge clk);
        check("gen_en_low_after_last_tap", 32'(gen_en), 32'd0);
        check("busy_wait_swap", 32'(busy), 32'd1);
        check("write_count", 32'(wr_cnt - n0), 32'd100);
        check("writes_drained", 32'(exp_wr_q.size()), 32'd0);
        if (gate > 0) begin
            repeat (gate) @(negedge clk);
            check("gated_busy", 32'(busy), 32'd1);
            check("gated_bank", 32'(active_bank), 32'(exp_ab));
            check("gated_no_writes", 32'(wr_cnt - n0), 32'd100);
        end
        exp_ab = ~exp_ab;
        exp_done_q.push_back(exp_ab);
        swap_ok = 1'b1;
        @(negedge clk);
        swap_ok = 1'b0;
        check("bank_after_swap", 32'(active_bank), 32'(exp_ab));
        check("idle_after_swap", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_gen_en", 32'(gen_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_we", 32'(coef_we), 32'd0);
        check("rst_bank", 32'(active_bank), 32'd0);
        check("rst_gen_cfg", {gen_fs, gen_f_ln}, 32'd0);
        rst = 1'b0;
        exp_ab = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        rst = 1'b1; cfg_req = 1'b0; cfg_fs = '0; cfg_f_ln = '0;
        gen_valid = 1'b0; gen_value = '0; swap_ok = 1'b0;
        @(negedge clk);
        do_reset();

        // Basic load into bank 1, swap held off for 500 cycles.
        exp_cfg_q.push_back({16'd48000, 16'd4000});
        issue_cfg(16'd48000, 16'd4000);
        run_load(16'h0100, 14, 500);

        // Queued requests: the last one issued during the load must be the next one run.
        @(negedge clk);
        do_reset();
        exp_cfg_q.push_back({16'd48000, 16'd4000});
        issue_cfg(16'd48000, 16'd4000);
        fork
            run_load(16'h0200, 14, 0);
            begin
                repeat (100) @(negedge clk);
                issue_cfg(16'd8000, 16'd1000);
                repeat (100) @(negedge clk);
                exp_cfg_q.push_back({16'd16000, 16'd2000});
                issue_cfg(16'd16000, 16'd2000);
            end
        join
        run_load(16'h0300, 14, 0);
        check("bank_back_to_0", 32'(active_bank), 32'd0);

        // Back-to-back pulses: one write per cycle for the whole set.
        exp_cfg_q.push_back({16'd32000, 16'd3000});
        issue_cfg(16'd32000, 16'd3000);
        s0 = wr_cyc_q.size();
        run_load(16'h0600, 2, 0);
        check("b2b_write_span", 32'(wr_cyc_q[s0 + 99] - wr_cyc_q[s0]), 32'd99);

        // Watchdog: generator stalls after 10 taps.
        exp_cfg_q.push_back({16'd44100, 16'd5000});
        issue_cfg(16'd44100, 16'd5000);
        wait_gen_en();
        gen_taps(10, 16'h0400, 14);
        repeat (240) @(negedge clk);
        check("no_early_timeout", 32'(err), 32'd0);
        check("busy_before_timeout", 32'(busy), 32'd1);
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_gen_en", 32'(gen_en), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_bank", 32'(active_bank), 32'(exp_ab));
        check("timeout_writes_drained", 32'(exp_wr_q.size()), 32'd0);
        exp_cfg_q.push_back({16'd12000, 16'd3000});
        issue_cfg(16'd12000, 16'd3000);
        check("err_cleared", 32'(err), 32'd0);

        // Reset during the mirror write of tap 20, then a clean full load.
        wait_gen_en();
        gen_taps(21, 16'h0500, 14);
        do_reset();
        exp_cfg_q.push_back({16'd48000, 16'd4000});
        issue_cfg(16'd48000, 16'd4000);
        run_load(16'h0700, 14, 0);
        check("bank_after_reset_load", 32'(active_bank), 32'd1);

        repeat (5) @(negedge clk);
        check("final_writes_drained", 32'(exp_wr_q.size()), 32'd0);
        check("final_cfg_drained", 32'(exp_cfg_q.size()), 32'd0);
        check("final_done_drained", 32'(exp_done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
